// File: rtl/arbiter_nx1_if.sv
// AXI-Lite bundle shared by the upstream masters and the downstream slave of arbiter_nx1.
// Latency: none, wires only.
// Backpressure: carried by the per-channel valid/ready pairs.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;

  // Modport names are from the arbiter's point of view: "master" is the side
  // facing an upstream master (arbiter returns ready/response), "slave" is the
  // side facing the downstream slave (arbiter issues requests).
  modport master (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
  modport slave (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/arbiter_nx1.sv
// N-to-1 AXI-Lite arbiter with independent round-robin write and read arbiters.
// Latency: request to downstream valid is 1 cycle; responses pass combinationally.
// Backpressure: one outstanding transaction per channel; no new grant until the response handshake.
module arbiter_nx1 #(
  parameter int N          = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic        clk,
  input logic        rst_n,
  axi_lite_if.master m_axi [N-1:0],
  axi_lite_if.slave  s_axi
);
  localparam int ID_W = $clog2(N);
  localparam int SW   = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

  wr_state_e       wr_state_q, wr_state_d;
  rd_state_e       rd_state_q, rd_state_d;
  logic [ID_W-1:0] wgrant_q, wgrant_d, wlast_q, wlast_d;
  logic [ID_W-1:0] rgrant_q, rgrant_d, rlast_q, rlast_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;

  // Upstream signals flattened so they can be indexed by the grant.
  logic [N-1:0]          aw_req, w_vld, b_rdy, ar_req, r_rdy;
  logic [ADDR_WIDTH-1:0] aw_addr_m [N];
  logic [ADDR_WIDTH-1:0] ar_addr_m [N];
  logic [DATA_WIDTH-1:0] w_data_m  [N];
  logic [SW-1:0]         w_strb_m  [N];

  logic s_aw_vld, s_w_vld, s_b_rdy, s_ar_vld, s_r_rdy;
  logic aw_hs, w_hs;

  // First requester strictly above last, else lowest requester (wrap-around).
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] req, input logic [ID_W-1:0] last);
    logic [ID_W-1:0] pick_lo, pick_hi;
    logic            hit_hi;
    pick_lo = '0;
    pick_hi = '0;
    hit_hi  = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) pick_lo = ID_W'(j);
      if (req[j] && (j > int'(last))) begin
        pick_hi = ID_W'(j);
        hit_hi  = 1'b1;
      end
    end
    return hit_hi ? pick_hi : pick_lo;
  endfunction

  // Write channel: arbitrate on aw_valid, let AW and W complete in any order, then wait for B.
  always_comb begin
    wr_state_d = wr_state_q;
    wgrant_d   = wgrant_q;
    wlast_d    = wlast_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    s_aw_vld   = 1'b0;
    s_w_vld    = 1'b0;
    s_b_rdy    = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (|aw_req) begin
          wgrant_d   = rr_pick(aw_req, wlast_q);
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        s_aw_vld  = aw_req[wgrant_q] && !aw_done_q;
        s_w_vld   = w_vld[wgrant_q] && !w_done_q;
        aw_hs     = s_aw_vld && s_axi.aw_ready;
        w_hs      = s_w_vld && s_axi.w_ready;
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) wr_state_d = W_RESP;
      end
      W_RESP: begin
        s_b_rdy = b_rdy[wgrant_q];
        if (s_b_rdy && s_axi.b_valid) begin
          wr_state_d = W_IDLE;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wlast_d    = wgrant_q;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read channel: arbitrate on ar_valid, forward AR, then wait for R.
  always_comb begin
    rd_state_d = rd_state_q;
    rgrant_d   = rgrant_q;
    rlast_d    = rlast_q;
    s_ar_vld   = 1'b0;
    s_r_rdy    = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (|ar_req) begin
          rgrant_d   = rr_pick(ar_req, rlast_q);
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        s_ar_vld = ar_req[rgrant_q];
        if (s_ar_vld && s_axi.ar_ready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        s_r_rdy = r_rdy[rgrant_q];
        if (s_r_rdy && s_axi.r_valid) begin
          rd_state_d = R_IDLE;
          rlast_d    = rgrant_q;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // State registers; reset abandons any transaction and restores master 0 priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      wgrant_q   <= '0;
      rgrant_q   <= '0;
      wlast_q    <= ID_W'(N - 1);
      rlast_q    <= ID_W'(N - 1);
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wgrant_q   <= wgrant_d;
      rgrant_q   <= rgrant_d;
      wlast_q    <= wlast_d;
      rlast_q    <= rlast_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Per-master flattening and gated ready/response return paths.
  for (genvar i = 0; i < N; i++) begin : g_m
    localparam logic [ID_W-1:0] IDX = ID_W'(i);
    logic w_sel, r_sel;
    assign w_sel = (wgrant_q == IDX);
    assign r_sel = (rgrant_q == IDX);

    assign aw_req[i]    = m_axi[i].aw_valid;
    assign w_vld[i]     = m_axi[i].w_valid;
    assign b_rdy[i]     = m_axi[i].b_ready;
    assign ar_req[i]    = m_axi[i].ar_valid;
    assign r_rdy[i]     = m_axi[i].r_ready;
    assign aw_addr_m[i] = m_axi[i].aw_addr;
    assign ar_addr_m[i] = m_axi[i].ar_addr;
    assign w_data_m[i]  = m_axi[i].w_data;
    assign w_strb_m[i]  = m_axi[i].w_strb;

    assign m_axi[i].aw_ready = (wr_state_q == W_ADDR) && w_sel && !aw_done_q && s_axi.aw_ready;
    assign m_axi[i].w_ready  = (wr_state_q == W_ADDR) && w_sel && !w_done_q && s_axi.w_ready;
    assign m_axi[i].b_valid  = (wr_state_q == W_RESP) && w_sel && s_axi.b_valid;
    assign m_axi[i].b_resp   = ((wr_state_q == W_RESP) && w_sel) ? s_axi.b_resp : 2'b00;
    assign m_axi[i].ar_ready = (rd_state_q == R_ADDR) && r_sel && s_axi.ar_ready;
    assign m_axi[i].r_valid  = (rd_state_q == R_DATA) && r_sel && s_axi.r_valid;
    assign m_axi[i].r_data   = ((rd_state_q == R_DATA) && r_sel) ? s_axi.r_data : '0;
    assign m_axi[i].r_resp   = ((rd_state_q == R_DATA) && r_sel) ? s_axi.r_resp : 2'b00;
  end

  assign s_axi.aw_valid = s_aw_vld;
  assign s_axi.w_valid  = s_w_vld;
  assign s_axi.b_ready  = s_b_rdy;
  assign s_axi.ar_valid = s_ar_vld;
  assign s_axi.r_ready  = s_r_rdy;
  assign s_axi.aw_addr  = aw_addr_m[wgrant_q];
  assign s_axi.w_data   = w_data_m[wgrant_q];
  assign s_axi.w_strb   = w_strb_m[wgrant_q];
  assign s_axi.ar_addr  = ar_addr_m[rgrant_q];
endmodule

// File: tb/tb_arbiter_nx1.sv
// Directed bench for arbiter_nx1 with four upstream masters.
// Latency: checks 1-cycle request-to-valid and combinational response paths.
// Backpressure: exercises slave-side stalls and one-outstanding behaviour.
module tb_arbiter_nx1;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // Upstream drive/observe
  logic [3:0]  m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready;
  logic [31:0] m_aw_addr [4];
  logic [31:0] m_ar_addr [4];
  logic [31:0] m_w_data  [4];
  logic [3:0]  m_w_strb  [4];
  logic [3:0]  m_aw_ready, m_w_ready, m_b_valid, m_ar_ready, m_r_valid;
  logic [1:0]  m_b_resp [4];
  logic [1:0]  m_r_resp [4];
  logic [31:0] m_r_data [4];

  // Downstream drive/observe
  logic        s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid;
  logic [1:0]  s_b_resp, s_r_resp;
  logic [31:0] s_r_data;
  logic        s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready;
  logic [31:0] s_aw_addr, s_ar_addr, s_w_data;
  logic [3:0]  s_w_strb;

  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if [3:0] ();
  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

  for (genvar i = 0; i < 4; i++) begin : g_m
    assign m_if[i].aw_valid = m_aw_valid[i];
    assign m_if[i].aw_addr  = m_aw_addr[i];
    assign m_if[i].w_valid  = m_w_valid[i];
    assign m_if[i].w_data   = m_w_data[i];
    assign m_if[i].w_strb   = m_w_strb[i];
    assign m_if[i].b_ready  = m_b_ready[i];
    assign m_if[i].ar_valid = m_ar_valid[i];
    assign m_if[i].ar_addr  = m_ar_addr[i];
    assign m_if[i].r_ready  = m_r_ready[i];
    assign m_aw_ready[i]    = m_if[i].aw_ready;
    assign m_w_ready[i]     = m_if[i].w_ready;
    assign m_b_valid[i]     = m_if[i].b_valid;
    assign m_b_resp[i]      = m_if[i].b_resp;
    assign m_ar_ready[i]    = m_if[i].ar_ready;
    assign m_r_valid[i]     = m_if[i].r_valid;
    assign m_r_data[i]      = m_if[i].r_data;
    assign m_r_resp[i]      = m_if[i].r_resp;
  end

  assign s_if.aw_ready = s_aw_ready;
  assign s_if.w_ready  = s_w_ready;
  assign s_if.b_valid  = s_b_valid;
  assign s_if.b_resp   = s_b_resp;
  assign s_if.ar_ready = s_ar_ready;
  assign s_if.r_valid  = s_r_valid;
  assign s_if.r_data   = s_r_data;
  assign s_if.r_resp   = s_r_resp;
  assign s_aw_valid    = s_if.aw_valid;
  assign s_aw_addr     = s_if.aw_addr;
  assign s_w_valid     = s_if.w_valid;
  assign s_w_data      = s_if.w_data;
  assign s_w_strb      = s_if.w_strb;
  assign s_b_ready     = s_if.b_ready;
  assign s_ar_valid    = s_if.ar_valid;
  assign s_ar_addr     = s_if.ar_addr;
  assign s_r_ready     = s_if.r_ready;

  arbiter_nx1 #(.N(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m_axi (m_if),
    .s_axi (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_aw_valid = '0; m_w_valid = '0; m_b_ready = '0; m_ar_valid = '0; m_r_ready = '0;
    for (int i = 0; i < 4; i++) begin
      m_aw_addr[i] = 32'h100 + 32'(i); m_ar_addr[i] = 32'h200 + 32'(i);
      m_w_data[i] = 32'hA000_0000 + 32'(i); m_w_strb[i] = 4'hF;
    end
    s_aw_ready = 1'b0; s_w_ready = 1'b0; s_b_valid = 1'b0; s_ar_ready = 1'b0; s_r_valid = 1'b0;
    s_b_resp = 2'b00; s_r_resp = 2'b00; s_r_data = 32'h0;
  endtask

  task automatic do_reset();
    tick(); rst_n = 1'b0; clear_inputs();
    tick(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs(); rst_n = 1'b0;
    tick();
    m_aw_valid = 4'hF; m_ar_valid = 4'hF; m_w_valid = 4'hF;
    s_aw_ready = 1'b1; s_w_ready = 1'b1; s_ar_ready = 1'b1; s_b_valid = 1'b1; s_r_valid = 1'b1;
    #1;
    checks++; if (s_aw_valid !== 1'b0) begin failures++; $display("FAIL reset_s_aw_valid got=%0h exp=0", s_aw_valid); end
    checks++; if (s_ar_valid !== 1'b0) begin failures++; $display("FAIL reset_s_ar_valid got=%0h exp=0", s_ar_valid); end
    checks++; if ({s_b_ready, s_r_ready, s_w_valid} !== 3'b000) begin failures++; $display("FAIL reset_s_rdy got=%0h exp=0", {s_b_ready, s_r_ready, s_w_valid}); end
    checks++; if (m_aw_ready !== 4'h0 || m_ar_ready !== 4'h0) begin failures++; $display("FAIL reset_m_ready got=%0h/%0h exp=0/0", m_aw_ready, m_ar_ready); end
    tick(); #1;
    checks++; if ({m_b_valid, m_r_valid} !== 8'h00) begin failures++; $display("FAIL reset_m_resp got=%0h exp=0", {m_b_valid, m_r_valid}); end
    checks++; if (s_aw_valid !== 1'b0) begin failures++; $display("FAIL reset_hold_aw got=%0h exp=0", s_aw_valid); end
    clear_inputs();
    tick(); rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    tick(); clear_inputs();
    m_aw_valid[2] = 1'b1; m_aw_addr[2] = 32'h10; m_w_valid[2] = 1'b1;
    m_w_data[2] = 32'hDEADBEEF; m_w_strb[2] = 4'hF; m_b_ready[2] = 1'b1;
    #1;
    checks++; if (s_aw_valid !== 1'b0) begin failures++; $display("FAIL sw_idle_aw_valid got=%0h exp=0", s_aw_valid); end
    tick(); #1;
    checks++; if (s_aw_valid !== 1'b1) begin failures++; $display("FAIL sw_aw_valid got=%0h exp=1", s_aw_valid); end
    checks++; if (s_aw_addr !== 32'h10) begin failures++; $display("FAIL sw_aw_addr got=%0h exp=10", s_aw_addr); end
    checks++; if (s_w_data !== 32'hDEADBEEF || s_w_strb !== 4'hF) begin failures++; $display("FAIL sw_w_data got=%0h/%0h exp=deadbeef/f", s_w_data, s_w_strb); end
    checks++; if (m_aw_ready !== 4'h0) begin failures++; $display("FAIL sw_aw_ready_stall got=%0h exp=0", m_aw_ready); end
    s_aw_ready = 1'b1; s_w_ready = 1'b1; #1;
    checks++; if (m_aw_ready !== 4'b0100 || m_w_ready !== 4'b0100) begin failures++; $display("FAIL sw_ready got=%0h/%0h exp=4/4", m_aw_ready, m_w_ready); end
    tick(); m_aw_valid[2] = 1'b0; m_w_valid[2] = 1'b0; s_b_valid = 1'b1; s_b_resp = 2'b00; #1;
    checks++; if (s_aw_valid !== 1'b0 || s_b_ready !== 1'b1) begin failures++; $display("FAIL sw_resp got=%0h/%0h exp=0/1", s_aw_valid, s_b_ready); end
    checks++; if (m_b_valid !== 4'b0100 || m_b_resp[2] !== 2'b00) begin failures++; $display("FAIL sw_b_valid got=%0h/%0h exp=4/0", m_b_valid, m_b_resp[2]); end
    tick(); s_b_valid = 1'b0; #1;
    checks++; if (s_b_ready !== 1'b0 || m_b_valid !== 4'h0) begin failures++; $display("FAIL sw_done got=%0h/%0h exp=0/0", s_b_ready, m_b_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] got;
    logic [3:0] exp;
    do_reset();
    s_aw_ready = 1'b1; s_w_ready = 1'b1; s_b_valid = 1'b1;
    m_b_ready = 4'hF; m_w_valid = 4'hF; m_aw_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp = (k == 4) ? 4'b0001 : 4'(1 << k);
      got = '0;
      for (int c = 0; c < 6 && got == 4'h0; c++) begin
        tick(); #1;
        got = m_aw_ready;
      end
      checks++; if (got !== exp) begin failures++; $display("FAIL rr_grant_%0d got=%0h exp=%0h", k, got, exp); end
      tick();
      m_aw_valid = m_aw_valid & ~exp; m_w_valid = m_w_valid & ~exp;
      if (k == 3) begin m_aw_valid[0] = 1'b1; m_w_valid[0] = 1'b1; end
      #1;
      checks++; if (m_b_valid !== exp) begin failures++; $display("FAIL rr_b_valid_%0d got=%0h exp=%0h", k, m_b_valid, exp); end
    end
    tick(); clear_inputs();
  endtask

  task automatic test_w_late();
    tick(); clear_inputs();
    s_aw_ready = 1'b1; s_w_ready = 1'b1; s_b_valid = 1'b1;
    m_b_ready[1] = 1'b1; m_aw_valid[1] = 1'b1;
    tick(); #1;
    checks++; if (m_aw_ready !== 4'b0010 || s_w_valid !== 1'b0) begin failures++; $display("FAIL wl_aw got=%0h/%0h exp=2/0", m_aw_ready, s_w_valid); end
    checks++; if (s_b_ready !== 1'b0 || m_b_valid !== 4'h0) begin failures++; $display("FAIL wl_early_b got=%0h/%0h exp=0/0", s_b_ready, m_b_valid); end
    tick(); m_aw_valid[1] = 1'b0; #1;
    checks++; if (s_aw_valid !== 1'b0 || s_b_ready !== 1'b0 || m_aw_ready !== 4'h0) begin failures++; $display("FAIL wl_wait1 got=%0h/%0h/%0h exp=0/0/0", s_aw_valid, s_b_ready, m_aw_ready); end
    tick(); #1;
    checks++; if (s_b_ready !== 1'b0 || m_w_ready !== 4'b0010) begin failures++; $display("FAIL wl_wait2 got=%0h/%0h exp=0/2", s_b_ready, m_w_ready); end
    tick(); m_w_valid[1] = 1'b1; #1;
    checks++; if (s_w_valid !== 1'b1 || s_b_ready !== 1'b0) begin failures++; $display("FAIL wl_w got=%0h/%0h exp=1/0", s_w_valid, s_b_ready); end
    tick(); m_w_valid[1] = 1'b0; #1;
    checks++; if (s_b_ready !== 1'b1 || m_b_valid !== 4'b0010) begin failures++; $display("FAIL wl_b got=%0h/%0h exp=1/2", s_b_ready, m_b_valid); end
    tick(); s_b_valid = 1'b0; #1;
    checks++; if (s_b_ready !== 1'b0) begin failures++; $display("FAIL wl_idle got=%0h exp=0", s_b_ready); end
  endtask

  task automatic test_parallel();
    tick(); clear_inputs();
    m_ar_valid[1] = 1'b1; m_ar_addr[1] = 32'h20; m_r_ready[1] = 1'b1;
    m_aw_valid[3] = 1'b1; m_aw_addr[3] = 32'h30; m_w_valid[3] = 1'b1; m_b_ready[3] = 1'b1;
    s_ar_ready = 1'b1; s_aw_ready = 1'b1; s_w_ready = 1'b1;
    s_r_data = 32'h12345678; s_r_resp = 2'b00; s_b_resp = 2'b10;
    #1;
    checks++; if (s_ar_valid !== 1'b0 || s_aw_valid !== 1'b0) begin failures++; $display("FAIL par_idle got=%0h/%0h exp=0/0", s_ar_valid, s_aw_valid); end
    tick(); #1;
    checks++; if (s_ar_valid !== 1'b1 || s_ar_addr !== 32'h20) begin failures++; $display("FAIL par_ar got=%0h/%0h exp=1/20", s_ar_valid, s_ar_addr); end
    checks++; if (s_aw_valid !== 1'b1 || s_aw_addr !== 32'h30) begin failures++; $display("FAIL par_aw got=%0h/%0h exp=1/30", s_aw_valid, s_aw_addr); end
    checks++; if (m_ar_ready !== 4'b0010 || m_aw_ready !== 4'b1000) begin failures++; $display("FAIL par_ready got=%0h/%0h exp=2/8", m_ar_ready, m_aw_ready); end
    tick(); m_ar_valid[1] = 1'b0; m_aw_valid[3] = 1'b0; m_w_valid[3] = 1'b0; s_r_valid = 1'b1; s_b_valid = 1'b1; #1;
    checks++; if (m_r_valid !== 4'b0010 || m_r_data[1] !== 32'h12345678 || m_r_resp[1] !== 2'b00) begin failures++; $display("FAIL par_r1 got=%0h/%0h exp=2/12345678", m_r_valid, m_r_data[1]); end
    checks++; if (m_r_data[0] !== 32'h0 || m_r_data[2] !== 32'h0 || m_r_data[3] !== 32'h0) begin failures++; $display("FAIL par_r_other got=%0h/%0h/%0h exp=0/0/0", m_r_data[0], m_r_data[2], m_r_data[3]); end
    checks++; if (m_b_valid !== 4'b1000 || m_b_resp[3] !== 2'b10 || m_b_resp[1] !== 2'b00) begin failures++; $display("FAIL par_b got=%0h/%0h/%0h exp=8/2/0", m_b_valid, m_b_resp[3], m_b_resp[1]); end
    checks++; if (s_r_ready !== 1'b1 || s_b_ready !== 1'b1) begin failures++; $display("FAIL par_s_rdy got=%0h/%0h exp=1/1", s_r_ready, s_b_ready); end
    tick(); s_r_valid = 1'b0; s_b_valid = 1'b0; #1;
    checks++; if (m_r_valid !== 4'h0 || m_r_data[1] !== 32'h0 || s_r_ready !== 1'b0) begin failures++; $display("FAIL par_done got=%0h/%0h/%0h exp=0/0/0", m_r_valid, m_r_data[1], s_r_ready); end
  endtask

  task automatic test_b_delay();
    tick(); clear_inputs();
    s_aw_ready = 1'b1; s_w_ready = 1'b1;
    m_aw_valid[2] = 1'b1; m_w_valid[2] = 1'b1; m_b_ready[2] = 1'b1;
    tick(); #1;
    checks++; if (m_aw_ready !== 4'b0100) begin failures++; $display("FAIL bd_grant2 got=%0h exp=4", m_aw_ready); end
    tick();
    m_aw_valid[2] = 1'b0; m_w_valid[2] = 1'b0;
    m_aw_valid[0] = 1'b1; m_w_valid[0] = 1'b1; m_b_ready[0] = 1'b1;
    for (int d = 0; d < 5; d++) begin
      if (d > 0) tick();
      #1;
      checks++; if (m_aw_ready[0] !== 1'b0) begin failures++; $display("FAIL bd_stall_%0d got=%0h exp=0", d, m_aw_ready[0]); end
    end
    tick(); s_b_valid = 1'b1; #1;
    checks++; if (m_b_valid !== 4'b0100 || m_aw_ready !== 4'h0) begin failures++; $display("FAIL bd_b got=%0h/%0h exp=4/0", m_b_valid, m_aw_ready); end
    tick(); s_b_valid = 1'b0; #1;
    checks++; if (m_aw_ready !== 4'h0) begin failures++; $display("FAIL bd_idle got=%0h exp=0", m_aw_ready); end
    tick(); #1;
    checks++; if (m_aw_ready !== 4'b0001) begin failures++; $display("FAIL bd_grant0 got=%0h exp=1", m_aw_ready); end
    tick(); m_aw_valid[0] = 1'b0; m_w_valid[0] = 1'b0; s_b_valid = 1'b1; #1;
    checks++; if (m_b_valid !== 4'b0001) begin failures++; $display("FAIL bd_b0 got=%0h exp=1", m_b_valid); end
    tick(); s_b_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick(); clear_inputs();
    s_aw_ready = 1'b1; s_w_ready = 1'b1; s_ar_ready = 1'b1;
    m_aw_valid[1] = 1'b1; m_w_valid[1] = 1'b1; m_b_ready[1] = 1'b1;
    m_ar_valid[3] = 1'b1; m_r_ready[3] = 1'b1;
    tick(); #1;
    checks++; if (m_aw_ready !== 4'b0010 || m_ar_ready !== 4'b1000) begin failures++; $display("FAIL rm_grant got=%0h/%0h exp=2/8", m_aw_ready, m_ar_ready); end
    tick(); m_aw_valid[1] = 1'b0; m_w_valid[1] = 1'b0; m_ar_valid[3] = 1'b0; #1;
    checks++; if (s_b_ready !== 1'b1 || s_r_ready !== 1'b1) begin failures++; $display("FAIL rm_resp_state got=%0h/%0h exp=1/1", s_b_ready, s_r_ready); end
    tick(); rst_n = 1'b0; s_b_valid = 1'b1; s_r_valid = 1'b1; s_r_data = 32'hCAFE0000; #1;
    checks++; if (s_b_ready !== 1'b0 || s_r_ready !== 1'b0) begin failures++; $display("FAIL rm_s_rdy got=%0h/%0h exp=0/0", s_b_ready, s_r_ready); end
    checks++; if (m_b_valid !== 4'h0 || m_r_valid !== 4'h0 || m_r_data[3] !== 32'h0) begin failures++; $display("FAIL rm_m_resp got=%0h/%0h/%0h exp=0/0/0", m_b_valid, m_r_valid, m_r_data[3]); end
    tick(); rst_n = 1'b1; #1;
    checks++; if (m_b_valid !== 4'h0 || m_r_valid !== 4'h0) begin failures++; $display("FAIL rm_after got=%0h/%0h exp=0/0", m_b_valid, m_r_valid); end
    tick(); s_b_valid = 1'b0; s_r_valid = 1'b0;
    m_aw_valid[2] = 1'b1; m_w_valid[2] = 1'b1; m_aw_valid[0] = 1'b1; m_w_valid[0] = 1'b1;
    tick(); #1;
    checks++; if (m_aw_ready !== 4'b0001 || s_aw_valid !== 1'b1) begin failures++; $display("FAIL rm_prio got=%0h/%0h exp=1/1", m_aw_ready, s_aw_valid); end
    tick(); clear_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_w_late();
    test_parallel();
    test_b_delay();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arbiter_nx1.md
ARBITER_NX1 -- requirements
Module: arbiter_nx1

Interface
REQ-001 Parameter N, default 4, number of upstream AXI-Lite masters (N >= 2).
REQ-002 Parameter ADDR_WIDTH, default 32, address width.
REQ-003 Parameter DATA_WIDTH, default 32, data width; strobe width DATA_WIDTH/8.
REQ-004 Localparam ID_W = $clog2(N), width of grant index.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 m_axi[N-1:0]  axi_lite_if.master  bundle  one port per upstream master; block drives aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp.
REQ-008 s_axi  axi_lite_if.slave  bundle  single downstream slave; block drives aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready.

Function
REQ-009 Write and read channels SHALL use two independent arbiters; a write and a read SHALL proceed concurrently, including from the same master.
REQ-010 Each arbiter SHALL allow exactly one outstanding transaction; no new grant until the current response handshake completes.
REQ-011 Write FSM SHALL have states W_IDLE, W_ADDR, W_RESP; read FSM SHALL have states R_IDLE, R_ADDR, R_DATA.
REQ-012 Write request i = m_axi[i].aw_valid; read request i = m_axi[i].ar_valid; w_valid alone SHALL NOT constitute a request.
REQ-013 In *_IDLE with any request, the FSM SHALL, at the next edge, register grant = first requester searching (last_grant+1) mod N upward with wrap, and move to *_ADDR.
REQ-014 last_grant SHALL update to the granted index on completion of the response handshake; its reset value SHALL be N-1 so master 0 has first priority.
REQ-015 In W_ADDR: s_axi.aw_valid = m_axi[g].aw_valid until the AW handshake, then 0; s_axi.w_valid = m_axi[g].w_valid until the W handshake, then 0; m_axi[g].aw_ready/w_ready pass s_axi ready under the same gating.
REQ-016 AW and W handshakes SHALL complete in either order or the same cycle; per-transaction flags aw_done, w_done record them; W_ADDR -> W_RESP on the edge where both are done (registered or current handshake).
REQ-017 In W_RESP: s_axi.b_ready = m_axi[g].b_ready; m_axi[g].b_valid/b_resp = s_axi.b_valid/b_resp; on B handshake -> W_IDLE and clear flags.
REQ-018 In R_ADDR: s_axi.ar_valid = m_axi[g].ar_valid, m_axi[g].ar_ready = s_axi.ar_ready; on AR handshake -> R_DATA.
REQ-019 In R_DATA: s_axi.r_ready = m_axi[g].r_ready; m_axi[g].r_valid/r_data/r_resp = s_axi values; on R handshake -> R_IDLE.
REQ-020 Non-granted masters, and all masters in *_IDLE, SHALL see ready = 0, b_valid = r_valid = 0, b_resp = r_resp = 0, r_data = 0.
REQ-021 s_axi.aw_valid, w_valid, ar_valid, b_ready, r_ready SHALL be 0 in any state other than the one that forwards them.
REQ-022 s_axi address, data, strobe SHALL be muxed from m_axi[g] in all states.
REQ-023 Latency: request to s_axi.*_valid = 1 cycle; responses pass combinationally; minimum 3 cycles per transaction per channel (IDLE, ADDR, RESP/DATA).
REQ-024 Slave response codes SHALL pass unmodified; the block SHALL generate no SLVERR/DECERR.
REQ-025 A master re-requesting while granted SHALL be served again only after the IDLE arbitration cycle, subject to round-robin.

Reset
REQ-026 On rst_n low, immediately and asynchronously: both FSMs -> *_IDLE, aw_done = w_done = 0, grants = 0, last_grant = N-1; all driven valid/ready outputs 0.
REQ-027 Reset mid-transaction SHALL abandon it; no response SHALL be delivered after deassertion.

Verification
REQ-028 Master 2 writes addr 0x10, data 0xDEADBEEF, strb 0xF; slave OKAY -> s_axi.aw_valid 1 cycle after request, b_valid/b_resp=0 at master 2 only.
REQ-029 Masters 0-3 assert aw_valid same cycle after reset, held until accepted -> grant order 0,1,2,3, then 0 on re-request.
REQ-030 Granted master 1 presents w_valid 3 cycles after AW handshake -> FSM stays W_ADDR; s_axi.b_ready asserted only after W handshake.
REQ-031 Master 1 reads 0x20 (slave r_data 0x12345678) while master 3 writes -> both complete in parallel; r_data reaches master 1 only, other masters see r_data 0.
REQ-032 Slave delays b_valid 5 cycles while master 0 requests write -> master 0 aw_ready stays 0 until the pending B handshake plus one IDLE cycle.
REQ-033 rst_n asserted in W_RESP and R_DATA -> all outputs 0 that cycle; after release, simultaneous requests from masters 2 and 0 grant master 0 first.
